// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the decode/datapath-facing signals of the PC and trap
// sequencer into one bundle.
//   master modport: core decode/datapath side. It drives stall, pc_src,
//                   branch/jump operands, illegal, eret, irq and the mask
//                   write port. It receives pc, pc_plus4, trap, irq_ack,
//                   epc, cause, irq_mask and kernel.
//   slave modport : the sequencer itself, with the opposite directions.
interface pc_sequencer_if #(
    parameter int NUM_IRQ = 4
);
    logic                stall;
    logic [1:0]          pc_src;
    logic                branch_taken;
    logic [15:0]         imm16;
    logic [25:0]         instr_index;
    logic [31:0]         jr_target;
    logic                illegal;
    logic                eret;
    logic [NUM_IRQ-1:0]  irq;
    logic                mask_we;
    logic [NUM_IRQ-1:0]  mask_wdata;
    logic [31:0]         pc;
    logic [31:0]         pc_plus4;
    logic                trap;
    logic [NUM_IRQ-1:0]  irq_ack;
    logic [31:0]         epc;
    logic [7:0]          cause;
    logic [NUM_IRQ-1:0]  irq_mask;
    logic                kernel;

    modport master (
        output stall, pc_src, branch_taken, imm16, instr_index, jr_target,
               illegal, eret, irq, mask_we, mask_wdata,
        input  pc, pc_plus4, trap, irq_ack, epc, cause, irq_mask, kernel
    );

    modport slave (
        input  stall, pc_src, branch_taken, imm16, instr_index, jr_target,
               illegal, eret, irq, mask_we, mask_wdata,
        output pc, pc_plus4, trap, irq_ack, epc, cause, irq_mask, kernel
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, next-PC selection and trap sequencing for the
// single-cycle MIPS core. Handles prioritised maskable interrupts (level or
// rising-edge per source), illegal-instruction exceptions, eret and stalls.
// Kernel mode is pc[31].
// Ports:
//   clk   - core clock
//   reset - synchronous, active-high; overrides everything including trap
//   bus   - pc_sequencer_if.slave: redirect controls in; pc, pc_plus4,
//           trap/irq_ack (combinational), epc, cause, irq_mask, kernel out
module pc_sequencer #(
    parameter logic [31:0]        RESET_VEC = 32'h8000_0000,
    parameter logic [31:0]        IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0]        EXC_VEC   = 32'h8000_0008,
    parameter logic [31:0]        VEC_BASE  = 32'h8000_0100,
    parameter int                 NUM_IRQ   = 4,
    parameter bit                 VECTORED  = 1'b0,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE  = '0
) (
    input  logic clk,
    input  logic reset,
    pc_sequencer_if.slave bus
);

    localparam logic [NUM_IRQ-1:0] IRQ_ONE = NUM_IRQ'(1'b1);

    // Index of the lowest set bit (highest priority source).
    function automatic logic [4:0] prio_index(input logic [NUM_IRQ-1:0] req);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = req[i] ? i[4:0] : idx;
        end
        return idx;
    endfunction

    logic [31:0]        pc_r;
    logic [31:0]        epc_r;
    logic [7:0]         cause_r;
    logic [NUM_IRQ-1:0] mask_r;
    logic [NUM_IRQ-1:0] edge_pend_r;
    logic [NUM_IRQ-1:0] irq_prev_r;

    logic [31:0]        pc_plus4_s;
    logic               kernel_s;
    logic [31:0]        branch_off_s;
    logic [31:0]        seq_next_s;
    logic [NUM_IRQ-1:0] pending_s;
    logic [NUM_IRQ-1:0] elig_s;
    logic [NUM_IRQ-1:0] winner_s;
    logic [4:0]         win_idx_s;
    logic [31:0]        irq_target_s;
    logic [31:0]        next_pc_s;
    logic [31:0]        next_epc_s;
    logic [7:0]         next_cause_s;
    logic               trap_s;
    logic [NUM_IRQ-1:0] ack_s;
    logic [NUM_IRQ-1:0] edge_pend_next_s;

    assign pc_plus4_s   = pc_r + 32'd4;
    assign kernel_s     = pc_r[31];
    assign branch_off_s = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

    // Level sources are pending while asserted; edge sources only via their
    // sticky bit, so an edge is trapped one cycle after it is latched.
    assign pending_s = (bus.irq & ~IRQ_EDGE) | (edge_pend_r & IRQ_EDGE);
    assign elig_s    = pending_s & mask_r;
    // Two's-complement trick isolates the lowest set bit.
    assign winner_s  = elig_s & (~elig_s + IRQ_ONE);
    assign win_idx_s = prio_index(elig_s);

    // Interrupt destination: fixed vector or per-source slot 8 bytes apart.
    always_comb begin
        irq_target_s = IRQ_VEC;
        if (VECTORED) begin
            irq_target_s = VEC_BASE + {24'd0, win_idx_s, 3'b000};
        end else begin
            irq_target_s = IRQ_VEC;
        end
    end

    // Ordinary next-PC mux; user-mode register jumps cannot set pc[31].
    always_comb begin
        seq_next_s = pc_plus4_s;
        case (bus.pc_src)
            2'b00: seq_next_s = pc_plus4_s;
            2'b01: begin
                if (bus.branch_taken) begin
                    seq_next_s = pc_plus4_s + branch_off_s;
                end else begin
                    seq_next_s = pc_plus4_s;
                end
            end
            2'b10: seq_next_s = {pc_plus4_s[31:28], bus.instr_index, 2'b00};
            2'b11: begin
                if (kernel_s) begin
                    seq_next_s = bus.jr_target;
                end else begin
                    seq_next_s = {1'b0, bus.jr_target[30:0]};
                end
            end
            default: seq_next_s = pc_plus4_s;
        endcase
    end

    // Redirect priority: reset, stall, illegal (incl. user eret), irq, eret, normal.
    always_comb begin
        next_pc_s    = pc_r;
        next_epc_s   = epc_r;
        next_cause_s = cause_r;
        trap_s       = 1'b0;
        ack_s        = '0;
        if (reset || bus.stall) begin
            next_pc_s = pc_r;
        end else if (bus.illegal || (bus.eret && !kernel_s)) begin
            trap_s       = 1'b1;
            next_pc_s    = EXC_VEC;
            next_cause_s = {1'b1, kernel_s, 1'b0, 5'd0};
            // A nested exception keeps the original user return address.
            if (!kernel_s) begin
                next_epc_s = pc_r;
            end else begin
                next_epc_s = epc_r;
            end
        end else if (!kernel_s && (elig_s != '0)) begin
            trap_s       = 1'b1;
            ack_s        = winner_s;
            next_pc_s    = irq_target_s;
            next_epc_s   = pc_r;
            next_cause_s = {3'b000, win_idx_s};
        end else if (bus.eret) begin
            next_pc_s = epc_r;
        end else begin
            next_pc_s = seq_next_s;
        end
    end

    // Sticky edge bits: a new rising edge wins over a same-cycle acknowledge.
    assign edge_pend_next_s = IRQ_EDGE &
                              ((edge_pend_r & ~ack_s) | (bus.irq & ~irq_prev_r));

    // Architectural state; edge sampling and mask writes ignore stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_VEC;
            epc_r       <= 32'd0;
            cause_r     <= 8'd0;
            mask_r      <= '0;
            edge_pend_r <= '0;
            irq_prev_r  <= '0;
        end else begin
            pc_r        <= next_pc_s;
            epc_r       <= next_epc_s;
            cause_r     <= next_cause_s;
            edge_pend_r <= edge_pend_next_s;
            irq_prev_r  <= bus.irq;
            if (bus.mask_we) begin
                mask_r <= bus.mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign bus.pc       = pc_r;
    assign bus.pc_plus4 = pc_plus4_s;
    assign bus.kernel   = kernel_s;
    assign bus.epc      = epc_r;
    assign bus.cause    = cause_r;
    assign bus.irq_mask = mask_r;
    assign bus.trap     = trap_s;
    assign bus.irq_ack  = ack_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. dut_a: irq[0] edge-triggered, fixed vector.
// dut_b: all-level, vectored; shares dut_a's stimulus and is only checked at
// the first interrupt, while both have seen identical history.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic        illegal;
    logic        eret;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    pc_sequencer_if #(.NUM_IRQ(4)) bus_a ();
    pc_sequencer_if #(.NUM_IRQ(4)) bus_b ();

    assign bus_a.stall = stall;        assign bus_b.stall = stall;
    assign bus_a.pc_src = pc_src;      assign bus_b.pc_src = pc_src;
    assign bus_a.branch_taken = branch_taken;
    assign bus_b.branch_taken = branch_taken;
    assign bus_a.imm16 = imm16;        assign bus_b.imm16 = imm16;
    assign bus_a.instr_index = instr_index;
    assign bus_b.instr_index = instr_index;
    assign bus_a.jr_target = jr_target; assign bus_b.jr_target = jr_target;
    assign bus_a.illegal = illegal;    assign bus_b.illegal = illegal;
    assign bus_a.eret = eret;          assign bus_b.eret = eret;
    assign bus_a.irq = irq;            assign bus_b.irq = irq;
    assign bus_a.mask_we = mask_we;    assign bus_b.mask_we = mask_we;
    assign bus_a.mask_wdata = mask_wdata;
    assign bus_b.mask_wdata = mask_wdata;

    pc_sequencer #(.IRQ_EDGE(4'b0001)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pc_sequencer #(.VECTORED(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc_src = 2'b00; branch_taken = 1'b0;
        imm16 = 16'h0000; instr_index = 26'd0; jr_target = 32'd0;
        illegal = 1'b0; eret = 1'b0; irq = 4'b0000;
        mask_we = 1'b0; mask_wdata = 4'b0000;

        // Reset state
        tick(); tick();
        chk("rst_pc", bus_a.pc, 32'h8000_0000);
        chk("rst_epc", bus_a.epc, 32'h0);
        chk("rst_cause", {24'd0, bus_a.cause}, 32'h0);
        chk("rst_mask", {28'd0, bus_a.irq_mask}, 32'h0);
        chk("rst_trap", {31'd0, bus_a.trap}, 32'h0);
        chk("rst_kernel", {31'd0, bus_a.kernel}, 32'h1);

        // Sequential fetch
        reset = 1'b0;
        tick(); chk("seq1", bus_a.pc, 32'h8000_0004);
        tick(); chk("seq2", bus_a.pc, 32'h8000_0008);
        chk("pc_plus4", bus_a.pc_plus4, 32'h8000_000C);

        // Kernel jr to user, then user jr cannot set bit 31
        pc_src = 2'b11; jr_target = 32'h0000_0100;
        tick(); chk("jr_kernel", bus_a.pc, 32'h0000_0100);
        jr_target = 32'h8000_0040;
        tick(); chk("jr_user_force", bus_a.pc, 32'h0000_0040);
        chk("user_kernel_bit", {31'd0, bus_a.kernel}, 32'h0);
        jr_target = 32'h0000_0200;
        tick(); chk("jr_200", bus_a.pc, 32'h0000_0200);

        // Branch back by one word, not taken, then jump
        pc_src = 2'b01; branch_taken = 1'b1; imm16 = 16'hFFFF;
        tick(); chk("branch_taken", bus_a.pc, 32'h0000_0200);
        branch_taken = 1'b0;
        tick(); chk("branch_not", bus_a.pc, 32'h0000_0204);
        pc_src = 2'b10; instr_index = 26'h000_0040;
        tick(); chk("jump", bus_a.pc, 32'h0000_0100);

        // Level IRQ with priority (dut_b vectored)
        pc_src = 2'b11; jr_target = 32'h0000_0010; mask_we = 1'b1; mask_wdata = 4'hF;
        tick(); chk("pc_10", bus_a.pc, 32'h0000_0010);
        chk("mask_f", {28'd0, bus_a.irq_mask}, 32'hF);
        pc_src = 2'b00; mask_we = 1'b0; irq = 4'b1010;
        #1;
        chk("lvl_trap", {31'd0, bus_a.trap}, 32'h1);
        chk("lvl_ack", {28'd0, bus_a.irq_ack}, 32'h2);
        tick();
        chk("lvl_vec", bus_a.pc, 32'h8000_0004);
        chk("lvl_vec_b", bus_b.pc, 32'h8000_0108);
        chk("lvl_epc", bus_a.epc, 32'h0000_0010);
        chk("lvl_cause", {24'd0, bus_a.cause}, 32'h01);
        chk("lvl_kernel_notrap", {31'd0, bus_a.trap}, 32'h0);
        irq = 4'b0000; eret = 1'b1;
        tick(); chk("lvl_eret", bus_a.pc, 32'h0000_0010);
        eret = 1'b0;

        // Edge IRQ latched in kernel, taken on return to user
        pc_src = 2'b11; jr_target = 32'h0000_0030;
        tick(); chk("pc_30", bus_a.pc, 32'h0000_0030);
        pc_src = 2'b00; illegal = 1'b1;
        tick(); chk("exc_30_epc", bus_a.epc, 32'h0000_0030);
        illegal = 1'b0; pc_src = 2'b11; jr_target = 32'h8000_0020;
        tick(); chk("pc_k20", bus_a.pc, 32'h8000_0020);
        pc_src = 2'b00; irq = 4'b0001;
        #1; chk("edge_k_notrap1", {31'd0, bus_a.trap}, 32'h0);
        tick(); irq = 4'b0000;
        #1; chk("edge_k_notrap2", {31'd0, bus_a.trap}, 32'h0);
        eret = 1'b1;
        tick(); chk("edge_eret", bus_a.pc, 32'h0000_0030);
        eret = 1'b0;
        #1;
        chk("edge_trap", {31'd0, bus_a.trap}, 32'h1);
        chk("edge_ack", {28'd0, bus_a.irq_ack}, 32'h1);
        tick();
        chk("edge_vec", bus_a.pc, 32'h8000_0004);
        chk("edge_cause", {24'd0, bus_a.cause}, 32'h00);
        eret = 1'b1;
        tick(); eret = 1'b0;
        #1;
        chk("edge_ret_pc", bus_a.pc, 32'h0000_0030);
        chk("edge_no_second", {31'd0, bus_a.trap}, 32'h0);

        // Illegal, nested illegal, user eret
        pc_src = 2'b11; jr_target = 32'h0000_0050;
        tick(); pc_src = 2'b00; illegal = 1'b1;
        #1;
        chk("ill_trap", {31'd0, bus_a.trap}, 32'h1);
        chk("ill_noack", {28'd0, bus_a.irq_ack}, 32'h0);
        tick();
        chk("ill_pc", bus_a.pc, 32'h8000_0008);
        chk("ill_epc", bus_a.epc, 32'h0000_0050);
        chk("ill_cause", {24'd0, bus_a.cause}, 32'h80);
        tick();
        chk("nest_cause", {24'd0, bus_a.cause}, 32'hC0);
        chk("nest_epc", bus_a.epc, 32'h0000_0050);
        illegal = 1'b0; eret = 1'b1;
        tick(); chk("nest_eret", bus_a.pc, 32'h0000_0050);
        #1; chk("ueret_trap", {31'd0, bus_a.trap}, 32'h1);
        tick();
        chk("ueret_pc", bus_a.pc, 32'h8000_0008);
        chk("ueret_cause", {24'd0, bus_a.cause}, 32'h80);
        tick(); eret = 1'b0;
        chk("ueret_back", bus_a.pc, 32'h0000_0050);

        // Stall with eligible irq, mask cleared during stall
        stall = 1'b1; irq = 4'b0010;
        #1;
        chk("stall_trap", {31'd0, bus_a.trap}, 32'h0);
        chk("stall_ack", {28'd0, bus_a.irq_ack}, 32'h0);
        tick(); chk("stall_pc", bus_a.pc, 32'h0000_0050);
        mask_we = 1'b1; mask_wdata = 4'h0;
        tick(); chk("stall_mask", {28'd0, bus_a.irq_mask}, 32'h0);
        mask_we = 1'b0; stall = 1'b0;
        #1; chk("unstall_notrap", {31'd0, bus_a.trap}, 32'h0);
        tick(); chk("unstall_pc", bus_a.pc, 32'h0000_0054);

        // Reset in the trap cycle of an edge interrupt
        mask_we = 1'b1; mask_wdata = 4'hF; irq = 4'b0001;
        #1; chk("mask_delay", {31'd0, bus_a.trap}, 32'h0);
        tick(); mask_we = 1'b0; irq = 4'b0000;
        #1; chk("pre_rst_trap", {31'd0, bus_a.trap}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_trap_trap", {31'd0, bus_a.trap}, 32'h0);
        chk("rst_trap_ack", {28'd0, bus_a.irq_ack}, 32'h0);
        tick();
        chk("rst_trap_pc", bus_a.pc, 32'h8000_0000);
        chk("rst_trap_epc", bus_a.epc, 32'h0);
        reset = 1'b0;

        // Pending cleared by reset; PC wrap
        pc_src = 2'b11; jr_target = 32'hFFFF_FFFC; mask_we = 1'b1; mask_wdata = 4'hF;
        tick(); mask_we = 1'b0; pc_src = 2'b00;
        chk("wrap_plus4", bus_a.pc_plus4, 32'h0);
        tick();
        chk("wrap_pc", bus_a.pc, 32'h0);
        chk("rst_pend_clr", {31'd0, bus_a.trap}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
